// File: rtl/mask_burst_scheduler.sv
// mask_burst_scheduler
//   Shares one lane-mask generator / masked-write port among NUM_REQ
//   requesters. Each request is a burst (start lane + beats-minus-1).
//   Requesters are granted round-robin. The lane address then steps one
//   lane per downstream handshake.
//
//   Ports
//     clk, rst     clock and synchronous active-high reset
//     iReqVld      per-requester request valid
//     oReqRdy      per-requester accept (one-hot or zero, combinational in IDLE)
//     iReqAddr     packed start lane per requester
//     iReqLen      packed beats-minus-1 per requester
//     oMaskVld     beat valid
//     iMaskRdy     downstream accepts beat
//     oMask        decoded lane mask of current beat
//     oMaskAddr    current lane address
//     oMaskOwner   index of the granted requester
//     oMaskLast    final beat of burst
//     oBusy        burst in progress
//
//   state | meaning
//   IDLE  | arbitrate; accept one request per visit
//   BURST | present beats until the last one is accepted
module mask_burst_scheduler #(
    parameter int NUM_REQ    = 2,
    parameter int WIDTH_ADDR = 3,
    parameter int WIDTH_BIT  = 8,
    parameter int WIDTH_OUT  = 48,
    parameter int WIDTH_LEN  = 4,
    parameter int MASK_FLAG  = 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            iReqVld,
    output logic [NUM_REQ-1:0]            oReqRdy,
    input  logic [NUM_REQ*WIDTH_ADDR-1:0] iReqAddr,
    input  logic [NUM_REQ*WIDTH_LEN-1:0]  iReqLen,
    output logic                          oMaskVld,
    input  logic                          iMaskRdy,
    output logic [WIDTH_OUT-1:0]          oMask,
    output logic [WIDTH_ADDR-1:0]         oMaskAddr,
    output logic [$clog2(NUM_REQ)-1:0]    oMaskOwner,
    output logic                          oMaskLast,
    output logic                          oBusy
);

    localparam int NUM_LANE = WIDTH_OUT / WIDTH_BIT;
    localparam int PW       = $clog2(NUM_REQ);
    // Level driven onto lanes that are not selected.
    localparam logic INACT  = (MASK_FLAG == 0) ? 1'b1 : 1'b0;

    if (WIDTH_OUT % WIDTH_BIT != 0) begin : g_chk_width
        $error("mask_burst_scheduler: WIDTH_OUT must be a multiple of WIDTH_BIT");
    end
    if (NUM_LANE > (2 ** WIDTH_ADDR)) begin : g_chk_lane
        $error("mask_burst_scheduler: NUM_LANE exceeds lane address range");
    end
    if ((MASK_FLAG != 0) && (MASK_FLAG != 1)) begin : g_chk_flag
        $error("mask_burst_scheduler: MASK_FLAG must be 0 or 1");
    end

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_BURST = 1'b1
    } state_t;

    state_t                 state_q;
    logic [WIDTH_ADDR-1:0]  addr_q;
    logic [WIDTH_ADDR-1:0]  addr_d;
    logic [WIDTH_LEN-1:0]   len_q;
    logic [WIDTH_LEN-1:0]   cnt_q;
    logic [PW-1:0]          owner_q;
    logic [PW-1:0]          ptr_q;

    logic [WIDTH_ADDR-1:0]  req_addr [NUM_REQ];
    logic [WIDTH_LEN-1:0]   req_len  [NUM_REQ];
    logic                   grant_vld;
    logic [PW-1:0]          grant_idx;
    logic [PW-1:0]          cand;
    logic                   last_beat;

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign req_addr[g] = iReqAddr[g*WIDTH_ADDR +: WIDTH_ADDR];
        assign req_len[g]  = iReqLen[g*WIDTH_LEN +: WIDTH_LEN];
    end

    // Search starts one past the last grant; ptr resets to NUM_REQ-1 so
    // requester 0 wins first.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        cand      = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = PW'((int'(ptr_q) + k) % NUM_REQ);
            if (!grant_vld && iReqVld[cand]) begin
                grant_vld = 1'b1;
                grant_idx = cand;
            end
        end
    end

    always_comb begin
        oReqRdy = '0;
        if (state_q == S_IDLE && grant_vld) begin
            oReqRdy[grant_idx] = 1'b1;
        end
    end

    // Out-of-range start lanes also fall back to lane 0 after their beat.
    assign addr_d    = (int'(addr_q) >= NUM_LANE - 1) ? '0 : addr_q + 1'b1;
    assign last_beat = (cnt_q == len_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            len_q   <= '0;
            cnt_q   <= '0;
            owner_q <= '0;
            ptr_q   <= PW'(NUM_REQ - 1);
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (grant_vld) begin
                        state_q <= S_BURST;
                        addr_q  <= req_addr[grant_idx];
                        len_q   <= req_len[grant_idx];
                        cnt_q   <= '0;
                        owner_q <= grant_idx;
                        ptr_q   <= grant_idx;
                    end
                end
                S_BURST: begin
                    if (iMaskRdy) begin
                        if (last_beat) begin
                            state_q <= S_IDLE;
                        end else begin
                            cnt_q  <= cnt_q + 1'b1;
                            addr_q <= addr_d;
                        end
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign oMaskVld   = (state_q == S_BURST);
    assign oBusy      = (state_q == S_BURST);
    assign oMaskLast  = (state_q == S_BURST) && last_beat;
    assign oMaskAddr  = addr_q;
    assign oMaskOwner = owner_q;

    always_comb begin
        oMask = {WIDTH_OUT{INACT}};
        for (int i = 0; i < NUM_LANE; i++) begin
            if ((state_q == S_BURST) && (int'(addr_q) == i)) begin
                oMask[i*WIDTH_BIT +: WIDTH_BIT] = {WIDTH_BIT{~INACT}};
            end
        end
    end

endmodule

// File: tb/tb_mask_burst_scheduler.sv
module tb_mask_burst_scheduler;

    localparam int NL = 6;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [1:0]  vld, rdy_o;
    logic [5:0]  addr;
    logic [7:0]  len;
    logic        mrdy, mvld, mlast, busy, mown;
    logic [47:0] mask;
    logic [2:0]  maddr;

    logic [1:0]  vld_f, rdy_o_f;
    logic [5:0]  addr_f;
    logic [7:0]  len_f;
    logic        mrdy_f, mvld_f, mlast_f, busy_f, mown_f;
    logic [47:0] mask_f;
    logic [2:0]  maddr_f;

    mask_burst_scheduler #(.MASK_FLAG(1)) dut (
        .clk(clk), .rst(rst), .iReqVld(vld), .oReqRdy(rdy_o), .iReqAddr(addr),
        .iReqLen(len), .oMaskVld(mvld), .iMaskRdy(mrdy), .oMask(mask),
        .oMaskAddr(maddr), .oMaskOwner(mown), .oMaskLast(mlast), .oBusy(busy)
    );

    mask_burst_scheduler #(.MASK_FLAG(0)) dut_f (
        .clk(clk), .rst(rst), .iReqVld(vld_f), .oReqRdy(rdy_o_f), .iReqAddr(addr_f),
        .iReqLen(len_f), .oMaskVld(mvld_f), .iMaskRdy(mrdy_f), .oMask(mask_f),
        .oMaskAddr(maddr_f), .oMaskOwner(mown_f), .oMaskLast(mlast_f), .oBusy(busy_f)
    );

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [2:0]  addr;
        logic        owner;
        logic        last;
        logic [47:0] mask;
    } beat_t;

    beat_t sb[$];

    function automatic logic [47:0] exp_mask(input int a, input bit flag);
        logic [47:0] m;
        m = '0;
        for (int i = 0; i < NL; i++) if (a == i) m[i*8 +: 8] = 8'hFF;
        return flag ? m : ~m;
    endfunction

    task automatic push_burst(input int own, input int a, input int l, input bit flag);
        int x;
        beat_t b;
        x = a;
        for (int k = 0; k <= l; k++) begin
            b.addr  = 3'(x);
            b.owner = 1'(own);
            b.last  = (k == l);
            b.mask  = exp_mask(x, flag);
            sb.push_back(b);
            x = (x >= NL - 1) ? 0 : x + 1;
        end
    endtask

    task automatic set_req(input int r, input int a, input int l);
        addr[r*3 +: 3] = 3'(a);
        len[r*4 +: 4]  = 4'(l);
        vld[r]         = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++; if (rdy_o !== 2'b00) begin errors++; $display("FAIL reset_rdy got %b exp 00", rdy_o); end
        checks++; if (mvld !== 1'b0) begin errors++; $display("FAIL reset_vld got %b exp 0", mvld); end
        checks++; if (mlast !== 1'b0) begin errors++; $display("FAIL reset_last got %b exp 0", mlast); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
        checks++; if (maddr !== 3'd0) begin errors++; $display("FAIL reset_addr got %0d exp 0", maddr); end
        checks++; if (mown !== 1'b0) begin errors++; $display("FAIL reset_owner got %0d exp 0", mown); end
        checks++; if (mask !== 48'h0) begin errors++; $display("FAIL reset_mask got %h exp 0", mask); end
        checks++; if (mask_f !== {48{1'b1}}) begin errors++; $display("FAIL reset_mask_inv got %h exp all ones", mask_f); end
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_single();
        beat_t e;
        @(posedge clk); #1;
        mrdy = 1'b1;
        set_req(0, 2, 2);
        #1;
        checks++; if (rdy_o !== 2'b01) begin errors++; $display("FAIL single_grant got %b exp 01", rdy_o); end
        push_burst(0, 2, 2, 1'b1);
        @(posedge clk); #1;
        vld = 2'b00;
        for (int c = 0; c < 10 && sb.size() > 0; c++) begin
            @(negedge clk);
            if (c == 0) begin
                checks++; if (mvld !== 1'b1) begin errors++; $display("FAIL single_latency got vld %b exp 1", mvld); end
            end
            if (mvld && mrdy) begin
                e = sb.pop_front();
                checks++;
                if ({maddr, mown, mlast, mask} !== e) begin
                    errors++; $display("FAIL single_beat got %h exp %h", {maddr, mown, mlast, mask}, e);
                end
            end
        end
        checks++; if (sb.size() != 0) begin errors++; $display("FAIL single_timeout left %0d exp 0", sb.size()); sb.delete(); end
        @(negedge clk);
        checks++; if ({busy, mvld, mask} !== 50'h0) begin errors++; $display("FAIL single_end got busy %b vld %b mask %h exp 0", busy, mvld, mask); end
    endtask

    task automatic test_wrap();
        beat_t e;
        @(posedge clk); #1;
        mrdy = 1'b1;
        set_req(1, 4, 3);
        #1;
        checks++; if (rdy_o !== 2'b10) begin errors++; $display("FAIL wrap_grant got %b exp 10", rdy_o); end
        push_burst(1, 4, 3, 1'b1);
        @(posedge clk); #1;
        vld = 2'b00;
        for (int c = 0; c < 12 && sb.size() > 0; c++) begin
            @(negedge clk);
            if (mvld && mrdy) begin
                e = sb.pop_front();
                checks++;
                if ({maddr, mown, mlast, mask} !== e) begin
                    errors++; $display("FAIL wrap_beat got %h exp %h", {maddr, mown, mlast, mask}, e);
                end
            end
        end
        checks++; if (sb.size() != 0) begin errors++; $display("FAIL wrap_timeout left %0d exp 0", sb.size()); sb.delete(); end
        @(posedge clk); #1;
    endtask

    task automatic test_arbitration();
        int gq[$];
        int last_g;
        int g;
        beat_t e;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        mrdy = 1'b1;
        set_req(0, 1, 0);
        set_req(1, 2, 0);
        gq = '{0, 1, 0, 1};
        last_g = -1;
        for (int cyc = 0; cyc < 8; cyc++) begin
            #1;
            if (rdy_o !== 2'b00) begin
                g = rdy_o[1] ? 1 : 0;
                checks++;
                if (gq.size() == 0) begin
                    errors++; $display("FAIL arb_extra_grant got %b exp none", rdy_o);
                end else begin
                    if (rdy_o !== (2'b01 << gq[0])) begin
                        errors++; $display("FAIL arb_order got %b exp owner %0d", rdy_o, gq[0]);
                    end
                    void'(gq.pop_front());
                end
                if (last_g >= 0) begin
                    checks++;
                    if (cyc - last_g != 2) begin errors++; $display("FAIL arb_gap got %0d exp 2", cyc - last_g); end
                end
                push_burst(g, g == 1 ? 2 : 1, 0, 1'b1);
                last_g = cyc;
            end
            @(negedge clk);
            if (mvld && mrdy) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++; $display("FAIL arb_unexpected_beat got addr %0d exp none", maddr);
                end else begin
                    e = sb.pop_front();
                    if ({maddr, mown, mlast, mask} !== e) begin
                        errors++; $display("FAIL arb_beat got %h exp %h", {maddr, mown, mlast, mask}, e);
                    end
                end
            end
            @(posedge clk); #1;
        end
        vld = 2'b00;
        checks++; if (gq.size() != 0 || sb.size() != 0) begin
            errors++; $display("FAIL arb_count got %0d grants %0d beats left exp 0", gq.size(), sb.size());
            sb.delete();
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic test_backpressure();
        int hs;
        int stall;
        beat_t e;
        hs = 0;
        stall = 0;
        mrdy = 1'b1;
        set_req(0, 0, 2);
        #1;
        checks++; if (rdy_o !== 2'b01) begin errors++; $display("FAIL bp_grant got %b exp 01", rdy_o); end
        push_burst(0, 0, 2, 1'b1);
        @(posedge clk); #1;
        vld = 2'b00;
        for (int c = 0; c < 15 && sb.size() > 0; c++) begin
            mrdy = !(hs == 1 && stall < 3);
            @(negedge clk);
            if (mvld && !mrdy) begin
                stall++;
                checks++;
                if (maddr !== 3'd1 || mask !== 48'h0000_0000_FF00 || mlast !== 1'b0) begin
                    errors++; $display("FAIL bp_hold got addr %0d mask %h last %b exp 1 0000_0000_FF00 0", maddr, mask, mlast);
                end
            end
            if (mvld && mrdy) begin
                hs++;
                e = sb.pop_front();
                checks++;
                if ({maddr, mown, mlast, mask} !== e) begin
                    errors++; $display("FAIL bp_beat got %h exp %h", {maddr, mown, mlast, mask}, e);
                end
            end
            if (sb.size() > 0) begin
                @(posedge clk); #1;
            end
        end
        checks++; if (hs != 3 || stall != 3) begin
            errors++; $display("FAIL bp_count got hs %0d stall %0d exp 3 3", hs, stall); sb.delete();
        end
        mrdy = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid();
        beat_t e;
        mrdy = 1'b1;
        set_req(0, 3, 5);
        #1;
        checks++; if (rdy_o !== 2'b01) begin errors++; $display("FAIL rmid_grant got %b exp 01", rdy_o); end
        push_burst(0, 3, 5, 1'b1);
        @(posedge clk); #1;
        vld = 2'b00;
        @(negedge clk);
        e = sb.pop_front();
        checks++;
        if ({maddr, mown, mlast, mask} !== e || mvld !== 1'b1) begin
            errors++; $display("FAIL rmid_beat1 got %h vld %b exp %h", {maddr, mown, mlast, mask}, mvld, e);
        end
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        set_req(0, 1, 0);
        set_req(1, 2, 0);
        #1;
        checks++; if (rdy_o !== 2'b01) begin errors++; $display("FAIL rmid_regrant got %b exp 01", rdy_o); end
        @(negedge clk);
        checks++; if ({mvld, busy, mlast, mask} !== 51'h0) begin
            errors++; $display("FAIL rmid_state got vld %b busy %b last %b mask %h exp 0", mvld, busy, mlast, mask);
        end
        sb.delete();
        @(posedge clk); #1;
        vld = 2'b00;
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic test_mask_flag0();
        beat_t e;
        mrdy_f = 1'b1;
        addr_f[2:0] = 3'd7;
        len_f[3:0]  = 4'd0;
        vld_f = 2'b01;
        #1;
        checks++; if (rdy_o_f !== 2'b01) begin errors++; $display("FAIL flag0_grant got %b exp 01", rdy_o_f); end
        push_burst(0, 7, 0, 1'b0);
        @(posedge clk); #1;
        vld_f = 2'b00;
        @(negedge clk);
        e = sb.pop_front();
        checks++;
        if ({maddr_f, mown_f, mlast_f, mask_f} !== e || mvld_f !== 1'b1) begin
            errors++; $display("FAIL flag0_beat got %h vld %b exp %h", {maddr_f, mown_f, mlast_f, mask_f}, mvld_f, e);
        end
        @(negedge clk);
        checks++; if (mvld_f !== 1'b0 || busy_f !== 1'b0 || mask_f !== {48{1'b1}}) begin
            errors++; $display("FAIL flag0_end got vld %b busy %b mask %h exp 0 0 all ones", mvld_f, busy_f, mask_f);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got timeout exp completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        vld = '0; addr = '0; len = '0; mrdy = 1'b0;
        vld_f = '0; addr_f = '0; len_f = '0; mrdy_f = 1'b0;
        test_reset();
        test_single();
        test_wrap();
        test_arbitration();
        test_backpressure();
        test_reset_mid();
        test_mask_flag0();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
